// File: rtl/alu_cmd_issue_if.sv
// Command/issue bus of the ALU issue stage: upstream command handshake and
// the registered command presented to the decoder/execution units.
interface alu_cmd_issue_if #(parameter int WIDTH = 16);
  logic             CMD_Valid;
  logic             CMD_Ready;
  logic [1:0]       CMD_FUN;
  logic [1:0]       CMD_SEL;
  logic [WIDTH-1:0] CMD_A;
  logic [WIDTH-1:0] CMD_B;
  logic             ALU_Stall;
  logic             ALU_Valid;
  logic [1:0]       ALU_FUN;
  logic [1:0]       ALU_SEL;
  logic [WIDTH-1:0] ALU_A;
  logic [WIDTH-1:0] ALU_B;

  modport slave (
    input  CMD_Valid, CMD_FUN, CMD_SEL, CMD_A, CMD_B, ALU_Stall,
    output CMD_Ready, ALU_Valid, ALU_FUN, ALU_SEL, ALU_A, ALU_B
  );

  modport master (
    output CMD_Valid, CMD_FUN, CMD_SEL, CMD_A, CMD_B, ALU_Stall,
    input  CMD_Ready, ALU_Valid, ALU_FUN, ALU_SEL, ALU_A, ALU_B
  );
endinterface

// File: rtl/alu_cmd_issue.sv
// ALU issue stage: command FIFO feeding a registered output stage with stall.
// Optional saturating issued-command counter enabled by `define ISSUE_COUNT_EN.
module alu_cmd_issue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            FLUSH,
  alu_cmd_issue_if.slave  bus,
  output logic [15:0]     Issue_Cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [1:0]       fun;
    logic [1:0]       sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_STALL} state_t;

  cmd_t          r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  cmd_t          r_out;
  state_t        r_state, w_next;
  logic          w_full, w_empty, w_push, w_pop, w_consume;

  // Extra wrap bit distinguishes full from empty when low bits match.
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_push  = bus.CMD_Valid && !w_full && !FLUSH;

  always_comb begin
    w_next    = r_state;
    w_consume = 1'b0;
    w_pop     = 1'b0;
    if (FLUSH) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            w_pop  = 1'b1;
            w_next = S_ISSUE;
          end
        end
        S_ISSUE, S_STALL: begin
          if (bus.ALU_Stall) begin
            w_next = S_STALL;
          end else begin
            w_consume = 1'b1;
            w_pop     = !w_empty;
            w_next    = w_empty ? S_IDLE : S_ISSUE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= S_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_out    <= '0;
    end else begin
      r_state <= w_next;
      if (FLUSH) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
          r_out    <= r_mem[r_rd_ptr[AW-1:0]];
        end
      end
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= '{fun: bus.CMD_FUN, sel: bus.CMD_SEL,
                                             a: bus.CMD_A, b: bus.CMD_B};
  end

  assign bus.CMD_Ready = !w_full;
  assign bus.ALU_Valid = (r_state != S_IDLE);
  assign bus.ALU_FUN   = r_out.fun;
  assign bus.ALU_SEL   = r_out.sel;
  assign bus.ALU_A     = r_out.a;
  assign bus.ALU_B     = r_out.b;

`ifdef ISSUE_COUNT_EN
  logic [15:0] r_cnt;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                             r_cnt <= '0;
    else if (w_consume && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
  end
  assign Issue_Cnt = r_cnt;
`else
  assign Issue_Cnt = 16'd0;
`endif
endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed bench for alu_cmd_issue: latency, fill/back-pressure, stall hold,
// streaming order, flush and asynchronous reset.
module tb_alu_cmd_issue;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        FLUSH = 1'b0;
  logic [15:0] Issue_Cnt;
  int          n_cmp = 0;
  int          n_err = 0;
  int          exp_cnt = 0;

  alu_cmd_issue_if #(.WIDTH(16)) bus ();

  alu_cmd_issue #(.WIDTH(16), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .bus(bus), .Issue_Cnt(Issue_Cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [1:0] f, input logic [1:0] s,
                     input logic [15:0] a, input logic [15:0] b);
    bus.CMD_Valid = v;
    bus.CMD_FUN   = f;
    bus.CMD_SEL   = s;
    bus.CMD_A     = a;
    bus.CMD_B     = b;
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  function automatic logic [35:0] fld(input logic [1:0] f, input logic [1:0] s,
                                      input logic [15:0] a, input logic [15:0] b);
    return {f, s, a, b};
  endfunction

  function automatic logic [35:0] cur();
    return {bus.ALU_FUN, bus.ALU_SEL, bus.ALU_A, bus.ALU_B};
  endfunction

  function automatic logic [35:0] fill_cmd(input int i);
    logic [1:0] f = 2'(i);
    logic [1:0] s = ~2'(i);
    return fld(f, s, 16'h1000 + 16'(i), 16'h8000 | 16'(i));
  endfunction

  initial begin
    logic [35:0] held;
    drv(1'b0, 2'b00, 2'b00, 16'h0, 16'h0);
    bus.ALU_Stall = 1'b0;
    #12;
    chk("rst_valid", {63'b0, bus.ALU_Valid}, 64'd0);
    chk("rst_fields", {28'b0, cur()}, 64'd0);
    chk("rst_ready", {63'b0, bus.CMD_Ready}, 64'd1);
    RST = 1'b1;
    @(negedge CLK);

    // Single command: push at edge k, visible after k+1, gone after k+2.
    drv(1'b1, 2'b00, 2'b01, 16'hFFFB, 16'h0003);
    tick();
    drv(1'b0, 2'b00, 2'b00, 16'h0, 16'h0);
    chk("single_lat0", {63'b0, bus.ALU_Valid}, 64'd0);
    tick();
    chk("single_valid", {63'b0, bus.ALU_Valid}, 64'd1);
    chk("single_fields", {28'b0, cur()}, {28'b0, fld(2'b00, 2'b01, 16'hFFFB, 16'h0003)});
    tick();
    exp_cnt += 1;
    chk("single_drop", {63'b0, bus.ALU_Valid}, 64'd0);
    chk("single_hold", {28'b0, cur()}, {28'b0, fld(2'b00, 2'b01, 16'hFFFB, 16'h0003)});

    // Fill under stall: c0 sits in the output stage, c1..c4 fill the FIFO.
    bus.ALU_Stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      {bus.CMD_FUN, bus.CMD_SEL, bus.CMD_A, bus.CMD_B} = fill_cmd(i);
      bus.CMD_Valid = 1'b1;
      tick();
    end
    chk("fill_ready", {63'b0, bus.CMD_Ready}, 64'd0);
    chk("fill_head", {28'b0, cur()}, {28'b0, fill_cmd(0)});
    {bus.CMD_FUN, bus.CMD_SEL, bus.CMD_A, bus.CMD_B} = fill_cmd(5);
    tick();
    chk("full_ready_hold", {63'b0, bus.CMD_Ready}, 64'd0);
    // Release stall while still offering c5: pop happens, push must not.
    bus.ALU_Stall = 1'b0;
    tick();
    bus.CMD_Valid = 1'b0;
    chk("full_ready_rise", {63'b0, bus.CMD_Ready}, 64'd1);
    chk("fill_order1", {28'b0, cur()}, {28'b0, fill_cmd(1)});
    for (int i = 2; i < 5; i++) begin
      tick();
      chk("fill_order", {28'b0, cur()}, {28'b0, fill_cmd(i)});
      chk("fill_valid", {63'b0, bus.ALU_Valid}, 64'd1);
    end
    tick();
    exp_cnt += 5;
    chk("fill_no5th", {63'b0, bus.ALU_Valid}, 64'd0);

    // Stall hold on a shift command.
    bus.ALU_Stall = 1'b1;
    drv(1'b1, 2'b11, 2'b10, 16'h8001, 16'h0004);
    tick();
    drv(1'b0, 2'b00, 2'b00, 16'h0, 16'h0);
    tick();
    held = fld(2'b11, 2'b10, 16'h8001, 16'h0004);
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", {63'b0, bus.ALU_Valid}, 64'd1);
      chk("stall_fields", {28'b0, cur()}, {28'b0, held});
      tick();
    end
    bus.ALU_Stall = 1'b0;
    tick();
    exp_cnt += 1;
    chk("stall_release", {63'b0, bus.ALU_Valid}, 64'd0);

    // Streaming: one push and one issue per cycle, order preserved.
    for (int i = 0; i < 22; i++) begin
      if (i < 20) drv(1'b1, 2'b01, 2'(i), 16'h2000 + 16'(i), 16'(-i));
      else        drv(1'b0, 2'b00, 2'b00, 16'h0, 16'h0);
      if (i >= 2) begin
        chk("stream_valid", {63'b0, bus.ALU_Valid}, 64'd1);
        chk("stream_data", {28'b0, cur()},
            {28'b0, fld(2'b01, 2'(i-2), 16'h2000 + 16'(i-2), 16'(-(i-2)))});
        chk("stream_ready", {63'b0, bus.CMD_Ready}, 64'd1);
      end
      tick();
    end
    exp_cnt += 20;
    chk("stream_end", {63'b0, bus.ALU_Valid}, 64'd0);

    // Flush with one presented and three queued; the flush-cycle push is dropped.
    bus.ALU_Stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      {bus.CMD_FUN, bus.CMD_SEL, bus.CMD_A, bus.CMD_B} = fill_cmd(i);
      bus.CMD_Valid = 1'b1;
      tick();
    end
    chk("pre_flush_valid", {63'b0, bus.ALU_Valid}, 64'd1);
`ifndef ISSUE_COUNT_EN
    exp_cnt = 0;
`endif
    chk("pre_flush_cnt", {48'b0, Issue_Cnt}, 64'(exp_cnt));
    {bus.CMD_FUN, bus.CMD_SEL, bus.CMD_A, bus.CMD_B} = fill_cmd(7);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    bus.CMD_Valid = 1'b0;
    chk("flush_valid", {63'b0, bus.ALU_Valid}, 64'd0);
    chk("flush_ready", {63'b0, bus.CMD_Ready}, 64'd1);
    chk("flush_fields", {28'b0, cur()}, {28'b0, fill_cmd(0)});
    bus.ALU_Stall = 1'b0;
    tick();
    tick();
    chk("flush_empty", {63'b0, bus.ALU_Valid}, 64'd0);
    chk("flush_cnt", {48'b0, Issue_Cnt}, 64'(exp_cnt));

    // Asynchronous reset mid-burst.
    bus.ALU_Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      {bus.CMD_FUN, bus.CMD_SEL, bus.CMD_A, bus.CMD_B} = fill_cmd(i + 1);
      bus.CMD_Valid = 1'b1;
      tick();
    end
    #2 RST = 1'b0;
    #1;
    chk("arst_valid", {63'b0, bus.ALU_Valid}, 64'd0);
    chk("arst_fields", {28'b0, cur()}, 64'd0);
    chk("arst_ready", {63'b0, bus.CMD_Ready}, 64'd1);
    chk("arst_cnt", {48'b0, Issue_Cnt}, 64'd0);
    bus.CMD_Valid = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    bus.ALU_Stall = 1'b0;
    tick();
    tick();
    chk("arst_lost", {63'b0, bus.ALU_Valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
